// File: rtl/incr_mon_pkg.sv
// rtl/incr_mon_pkg.sv - shared types and default sizes for the incrementing-sequence monitor
package incr_mon_pkg;

    typedef enum logic {
        IDLE  = 1'b0,   // waiting for a seed sample, no check performed
        TRACK = 1'b1    // every accepted sample is checked against prev+STEP
    } mon_state_e;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_STEP      = 1;
    localparam int DEF_TS_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up counter that sticks at all-ones, with sync clear
// Ports:
//   clk   clock, rising edge
//   rst_n asynchronous active-low reset, q -> 0
//   clr   synchronous clear, wins over inc
//   inc   count up by one unless already saturated
//   q     current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/incr_seq_monitor.sv
// rtl/incr_seq_monitor.sv - timestamps and checks an incrementing sample stream, re-emits it registered
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   clear                 sync clear of checker state; timestamp keeps running
//   in_valid/in_ready     input handshake, in_data is the sample
//   mon_valid/mon_ready   output handshake for mon_data/mon_time/mon_ok
//   err, err_count        sticky mismatch flag and saturating mismatch count
//   run_len               saturating count of consecutive matches
//   first_exp/act/time    expected value, actual value and timestamp of the first mismatch
module incr_seq_monitor
    import incr_mon_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int STEP      = DEF_STEP,
    parameter int TS_WIDTH  = DEF_TS_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 mon_valid,
    input  logic                 mon_ready,
    output logic [WIDTH-1:0]     mon_data,
    output logic [TS_WIDTH-1:0]  mon_time,
    output logic                 mon_ok,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] run_len,
    output logic [WIDTH-1:0]     first_exp,
    output logic [WIDTH-1:0]     first_act,
    output logic [TS_WIDTH-1:0]  first_time
);

    mon_state_e          state_q;
    mon_state_e          state_d;
    logic [WIDTH-1:0]    prev_q;
    logic [WIDTH-1:0]    exp_val;
    logic [TS_WIDTH-1:0] ts_q;
    logic                transfer;
    logic                checking;
    logic                match;
    logic                mismatch;
    logic                hit;
    logic                run_clr;

    // The output slot is free when empty or being drained this cycle, so a
    // steady stream flows at one sample per cycle. rst_n gates it so nothing
    // is accepted while the block is held in reset.
    assign in_ready = rst_n & ~clear & (~mon_valid | mon_ready);
    assign transfer = in_valid & in_ready;

    // Modulo 2^WIDTH: all-ones followed by zero is a legal step.
    assign exp_val  = prev_q + WIDTH'(STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        checking = 1'b0;
        match    = 1'b0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                checking = transfer;
                match    = (in_data == exp_val);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    assign mismatch = checking & ~match;
    assign hit      = checking & match;
    // A seed sample or a mismatch restarts the run; clear zeroes it too.
    assign run_clr  = clear | (transfer & ~hit);

    // Free-running timestamp; clear deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    // Resync on the actual value so one bad sample costs one error, not many.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else if (transfer) begin
            prev_q <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_valid <= 1'b0;
            mon_data  <= '0;
            mon_time  <= '0;
            mon_ok    <= 1'b0;
        end else if (clear) begin
            mon_valid <= 1'b0;
        end else if (transfer) begin
            mon_valid <= 1'b1;
            mon_data  <= in_data;
            mon_time  <= ts_q;
            mon_ok    <= ~mismatch;
        end else if (mon_ready) begin
            mon_valid <= 1'b0;
        end
    end

    // Capture only while err is still low, so later mismatches never overwrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err        <= 1'b0;
            first_exp  <= '0;
            first_act  <= '0;
            first_time <= '0;
        end else if (clear) begin
            err        <= 1'b0;
            first_exp  <= '0;
            first_act  <= '0;
            first_time <= '0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (!err) begin
                first_exp  <= exp_val;
                first_act  <= in_data;
                first_time <= ts_q;
            end
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_err_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (mismatch),
        .q     (err_count)
    );

    sat_counter #(.W(CNT_WIDTH)) u_run_len (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_clr),
        .inc   (hit),
        .q     (run_len)
    );

endmodule

// File: tb/tb_incr_seq_monitor.sv
// tb/tb_incr_seq_monitor.sv - randomized self-checking bench for incr_seq_monitor
module tb_incr_seq_monitor;

    localparam int CMAX  = 255;
    localparam int TSMOD = 65536;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        mon_valid;
    logic        mon_ready = 1'b0;
    logic [31:0] mon_data;
    logic [15:0] mon_time;
    logic        mon_ok;
    logic        err;
    logic [7:0]  err_count;
    logic [7:0]  run_len;
    logic [31:0] first_exp;
    logic [31:0] first_act;
    logic [15:0] first_time;

    always #5 clk = ~clk;

    incr_seq_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mon_valid  (mon_valid),
        .mon_ready  (mon_ready),
        .mon_data   (mon_data),
        .mon_time   (mon_time),
        .mon_ok     (mon_ok),
        .err        (err),
        .err_count  (err_count),
        .run_len    (run_len),
        .first_exp  (first_exp),
        .first_act  (first_act),
        .first_time (first_time)
    );

    typedef struct {
        logic [31:0] data;
        logic [15:0] t;
        logic        ok;
    } rec_t;

    // Reference model: scoreboard of samples awaiting handoff plus plain
    // integer bookkeeping of the checker statistics.
    rec_t        sb[$];
    logic [31:0] m_prev;
    bit          m_have;
    bit          m_err;
    int          m_errc;
    int          m_run;
    logic [31:0] m_fexp;
    logic [31:0] m_fact;
    logic [15:0] m_ftime;
    int          m_ts;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        sb.delete();
        m_prev  = '0;
        m_have  = 0;
        m_err   = 0;
        m_errc  = 0;
        m_run   = 0;
        m_fexp  = '0;
        m_fact  = '0;
        m_ftime = '0;
        m_ts    = 0;
    endfunction

    function automatic void model_clear();
        sb.delete();
        m_have  = 0;
        m_err   = 0;
        m_errc  = 0;
        m_run   = 0;
        m_fexp  = '0;
        m_fact  = '0;
        m_ftime = '0;
    endfunction

    // Advance the model by one rising edge using the inputs the bench drove.
    function automatic void model_edge();
        bit          xfer;
        bit          ok;
        logic [31:0] want;
        rec_t        r;
        if (clear) begin
            model_clear();
        end else begin
            xfer = in_valid && (sb.size() == 0 || mon_ready);
            if (sb.size() > 0 && mon_ready) begin
                void'(sb.pop_front());
            end
            if (xfer) begin
                ok   = 1;
                want = m_prev + 32'd1;
                if (!m_have) begin
                    m_run = 0;
                end else if (in_data == want) begin
                    m_run = (m_run + 1 > CMAX) ? CMAX : m_run + 1;
                end else begin
                    ok     = 0;
                    m_errc = (m_errc + 1 > CMAX) ? CMAX : m_errc + 1;
                    m_run  = 0;
                    if (!m_err) begin
                        m_fexp  = want;
                        m_fact  = in_data;
                        m_ftime = 16'(m_ts);
                    end
                    m_err = 1;
                end
                m_prev = in_data;
                m_have = 1;
                r.data = in_data;
                r.t    = 16'(m_ts);
                r.ok   = ok;
                sb.push_back(r);
            end
        end
        m_ts = (m_ts + 1) % TSMOD;
    endfunction

    task automatic check_outputs();
        check("mon_valid", mon_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            check("mon_data", mon_data, sb[0].data);
            check("mon_time", mon_time, sb[0].t);
            check("mon_ok", mon_ok, sb[0].ok);
        end
        check("err", err, m_err);
        check("err_count", err_count, m_errc);
        check("run_len", run_len, m_run);
        check("first_exp", first_exp, m_fexp);
        check("first_act", first_act, m_fact);
        check("first_time", first_time, m_ftime);
    endtask

    // Inputs are already driven; check in_ready, clock once, check outputs.
    task automatic step();
        #1;
        check("in_ready", in_ready, !clear && (sb.size() == 0 || mon_ready));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        #1;
        model_reset();
        check("rst_in_ready", in_ready, 0);
        check("rst_mon_valid", mon_valid, 0);
        check("rst_mon_data", mon_data, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_run_len", run_len, 0);
        check("rst_first_exp", first_exp, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // back-to-back matching samples
        mon_ready = 1'b1;
        send(32'd5);
        send(32'd6);
        send(32'd7);
        check("t1_run_len", run_len, 2);
        check("t1_err", err, 0);
        in_valid = 1'b0;
        step();

        // one mismatch then resync
        do_clear();
        send(32'd5);
        send(32'd6);
        send(32'd9);
        check("t2_mon_ok_bad", mon_ok, 0);
        check("t2_err_count", err_count, 1);
        check("t2_first_exp", first_exp, 7);
        check("t2_first_act", first_act, 9);
        send(32'd10);
        check("t2_mon_ok_resync", mon_ok, 1);
        check("t2_run_len", run_len, 1);

        // wrap is legal
        do_clear();
        send(32'hFFFF_FFFF);
        send(32'd0);
        check("t3_wrap_ok", mon_ok, 1);

        // back-pressure: sink stalls for three cycles
        for (int i = 0; i < 3; i++) begin
            mon_ready = 1'b0;
            send(m_prev + 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            mon_ready = 1'b1;
            send(m_prev + 32'd1);
        end

        // error-count saturation, first_* keep the first mismatch
        do_clear();
        send(32'd100);
        for (int i = 0; i < 300; i++) begin
            send(m_prev + 32'd2);
        end
        check("t5_err_count_sat", err_count, CMAX);
        check("t5_first_exp", first_exp, 101);
        check("t5_first_act", first_act, 102);

        // run-length saturation
        for (int i = 0; i < 300; i++) begin
            send(m_prev + 32'd1);
        end
        check("t5_run_len_sat", run_len, CMAX);
        check("t5_err_kept", err, 1);

        // clear mid-stream, then reseed
        send(m_prev + 32'd3);
        do_clear();
        check("t6_clr_err", err, 0);
        check("t6_clr_count", err_count, 0);
        check("t6_clr_valid", mon_valid, 0);
        send(32'd42);
        check("t6_clr_reseed_ok", mon_ok, 1);
        check("t6_clr_reseed_data", mon_data, 42);

        // reset mid-stream with a pending sample held by the sink
        mon_ready = 1'b0;
        send(32'd43);
        do_reset();
        send(32'd42);
        check("t6_rst_reseed_ok", mon_ok, 1);
        check("t6_rst_time", mon_time, 0);
        check("t6_rst_run_len", run_len, 0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            clear     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            mon_ready = ($urandom_range(0, 3) != 0);
            if (m_have && $urandom_range(0, 4) != 0) begin
                in_data = m_prev + 32'd1;
            end else begin
                in_data = $urandom;
            end
            step();
        end
        clear    = 1'b0;
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
